// File: rtl/l1_dcache_if.sv
// Core-side request/response and SystemBus consumer-port signals of the L1 data cache.
// The cache uses the slave modport; the core and L2 side use the master modport.
interface l1_dcache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_wmask;
    logic                      resp_valid;
    logic [DATA_WIDTH-1:0]     resp_rdata;

    logic                      bus_rw_valid;
    logic                      bus_rw_we;
    logic [ADDR_WIDTH-1:0]     bus_rw_addr;
    logic [LINE_WIDTH/8-1:0]   bus_w_mask;
    logic [LINE_WIDTH-1:0]     bus_w_data;
    logic                      bus_w_ce;
    logic                      bus_rw_ready;
    logic [LINE_WIDTH-1:0]     bus_r_data;
    logic                      bus_inv_valid;
    logic [ADDR_WIDTH-1:0]     bus_inv_addr;
    logic                      bus_inv_ready;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
               bus_rw_ready, bus_r_data, bus_inv_valid, bus_inv_addr,
        output req_ready, resp_valid, resp_rdata,
               bus_rw_valid, bus_rw_we, bus_rw_addr, bus_w_mask, bus_w_data, bus_w_ce,
               bus_inv_ready
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
               bus_rw_ready, bus_r_data, bus_inv_valid, bus_inv_addr,
        input  req_ready, resp_valid, resp_rdata,
               bus_rw_valid, bus_rw_we, bus_rw_addr, bus_w_mask, bus_w_data, bus_w_ce,
               bus_inv_ready
    );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with L2 invalidation
// support; a fill racing an invalidation of its own line is returned but never installed.
module l1_dcache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int LINES      = 64
) (
    input  logic        clk,
    input  logic        rst,
    l1_dcache_if.slave  cif
);
    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam int IDX   = $clog2(LINES);
    localparam int TAGW  = ADDR_WIDTH - IDX - OFF;
    localparam int MASKW = LINE_WIDTH / 8;
    localparam int BPW   = DATA_WIDTH / 8;
    localparam int WORDW = $clog2(LINE_WIDTH / DATA_WIDTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_RD_BUS = 3'd2;
    localparam logic [2:0] ST_WR_BUS = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BPW-1:0]        wmask_q, wmask_d;
    logic                  poison_q, poison_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAGW-1:0]       tag_q  [LINES];
    logic [LINE_WIDTH-1:0] data_q [LINES];

    logic [IDX-1:0]        req_idx, inv_idx;
    logic [TAGW-1:0]       req_tag, inv_tag;
    logic [WORDW-1:0]      req_word;
    logic                  hit, inv_hit, inv_same_line, install;
    logic [DATA_WIDTH-1:0] lookup_word, fill_word;
    logic                  rd_bus, wr_bus;
    logic                  unused_bits;

    assign req_idx  = addr_q[OFF +: IDX];
    assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAGW];
    assign req_word = addr_q[OFF-1 -: WORDW];
    assign inv_idx  = cif.bus_inv_addr[OFF +: IDX];
    assign inv_tag  = cif.bus_inv_addr[ADDR_WIDTH-1 -: TAGW];

    assign hit           = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign inv_hit       = cif.bus_inv_valid && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
    assign inv_same_line = cif.bus_inv_valid && (inv_idx == req_idx) && (inv_tag == req_tag);
    assign lookup_word   = data_q[req_idx][int'(req_word) * DATA_WIDTH +: DATA_WIDTH];
    assign fill_word     = cif.bus_r_data[int'(req_word) * DATA_WIDTH +: DATA_WIDTH];
    assign unused_bits   = ^{addr_q[OFF-WORDW-1:0], cif.bus_inv_addr[OFF-1:0]};

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        poison_d = poison_q;
        rdata_d  = rdata_q;
        valid_d  = valid_q;
        install  = 1'b0;

        if (inv_hit) valid_d[inv_idx] = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cif.req_valid) begin
                    we_d     = cif.req_we;
                    addr_d   = cif.req_addr;
                    wdata_d  = cif.req_wdata;
                    wmask_d  = cif.req_wmask;
                    poison_d = 1'b0;
                    rdata_d  = '0;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (we_q) begin
                    if (hit) valid_d[req_idx] = 1'b0;
                    state_d = ST_WR_BUS;
                end else if (hit) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_BUS;
                end
            end
            ST_RD_BUS: begin
                if (inv_same_line) poison_d = 1'b1;
                if (cif.bus_rw_ready) begin
                    rdata_d = fill_word;
                    install = !poison_q && !inv_same_line;
                    state_d = ST_RESP;
                end
            end
            ST_WR_BUS: begin
                if (cif.bus_rw_ready) begin
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Applied after the invalidation clear so a fill of a new tag survives a stale inv.
        if (install) valid_d[req_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            poison_q <= 1'b0;
            rdata_q  <= '0;
            valid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            poison_q <= poison_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: tag/data arrays are not reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= cif.bus_r_data;
        end
    end

    assign rd_bus = (state_q == ST_RD_BUS);
    assign wr_bus = (state_q == ST_WR_BUS);

    assign cif.req_ready    = (state_q == ST_IDLE);
    assign cif.resp_valid   = ((state_q == ST_LOOKUP) && !we_q && hit) || (state_q == ST_RESP);
    assign cif.resp_rdata   = ((state_q == ST_LOOKUP) && !we_q && hit) ? lookup_word :
                              (state_q == ST_RESP) ? rdata_q : '0;

    assign cif.bus_rw_valid = rd_bus || wr_bus;
    assign cif.bus_rw_we    = wr_bus;
    assign cif.bus_rw_addr  = (rd_bus || wr_bus) ? {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}} : '0;
    assign cif.bus_w_mask   = wr_bus ? (MASKW'(wmask_q) << (int'(req_word) * BPW)) : '0;
    assign cif.bus_w_data   = wr_bus ? {(LINE_WIDTH / DATA_WIDTH){wdata_q}} : '0;
    assign cif.bus_w_ce     = wr_bus;
    assign cif.bus_inv_ready = cif.bus_inv_valid;
endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: a behavioural L2 answers bus requests with a
// configurable latency while scenario tasks check hits, misses, writes and invalidations.
module tb_l1_dcache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_dcache_if bif ();
    l1_dcache dut (.clk(clk), .rst(rst), .cif(bif));

    int checks = 0;
    int failures = 0;
    int lat_cfg = 2;
    bit hold_bus = 1'b0;
    int bus_reads = 0;
    int bus_writes = 0;
    int bus_cycles = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_w_addr = '0;
    logic [15:0]  last_w_mask = '0;
    logic [127:0] last_w_data = '0;
    logic         last_w_ce = 1'b0;
    logic [127:0] mem [logic [31:0]];

    function automatic logic [127:0] init_line(input logic [31:0] a);
        logic [127:0] l;
        if (a == 32'h1000) return {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = {16'hC0DE, a[15:0]} + 32'(k);
        return l;
    endfunction

    function automatic logic [127:0] get_line(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_line(a);
    endfunction

    // L2 model: ready after lat_cfg cycles of bus_rw_valid, writes merged by byte mask.
    initial begin
        int wait_cnt;
        logic [127:0] l;
        wait_cnt = 0;
        bif.bus_rw_ready = 1'b0;
        bif.bus_r_data   = '0;
        forever begin
            @(posedge clk); #1;
            bif.bus_rw_ready = 1'b0;
            if (bif.bus_rw_valid) bus_cycles++;
            if (bif.bus_rw_valid && !rst && !hold_bus) begin
                wait_cnt++;
                if (wait_cnt >= lat_cfg) begin
                    wait_cnt = 0;
                    bif.bus_rw_ready = 1'b1;
                    l = get_line(bif.bus_rw_addr);
                    if (bif.bus_rw_we) begin
                        for (int b = 0; b < 16; b++)
                            if (bif.bus_w_mask[b]) l[b*8 +: 8] = bif.bus_w_data[b*8 +: 8];
                        mem[bif.bus_rw_addr] = l;
                        bus_writes++;
                        last_w_addr = bif.bus_rw_addr;
                        last_w_mask = bif.bus_w_mask;
                        last_w_data = bif.bus_w_data;
                        last_w_ce   = bif.bus_w_ce;
                    end else begin
                        bif.bus_r_data = l;
                        bus_reads++;
                        last_rd_addr = bif.bus_rw_addr;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Called #1 after an edge with the cache idle; returns the same way.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, output logic [31:0] rdata, output int n,
                          output bit got);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        bif.req_wmask = wmask;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        n = 1;
        while (!bif.resp_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        got   = bif.resp_valid;
        rdata = bif.resp_rdata;
        @(posedge clk); #1;
    endtask

    task automatic inv_pulse(input logic [31:0] addr, output logic ready_seen);
        bif.bus_inv_valid = 1'b1;
        bif.bus_inv_addr  = addr;
        #1;
        ready_seen = bif.bus_inv_ready;
        @(posedge clk); #1;
        bif.bus_inv_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bif.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b want 1", bif.req_ready); end
        checks++; if (bif.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b want 0", bif.resp_valid); end
        checks++; if (bif.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata: got %h want 0", bif.resp_rdata); end
        checks++; if (bif.bus_rw_valid !== 1'b0) begin failures++; $display("FAIL reset_bus_rw_valid: got %b want 0", bif.bus_rw_valid); end
        checks++; if (bif.bus_w_ce !== 1'b0) begin failures++; $display("FAIL reset_bus_w_ce: got %b want 0", bif.bus_w_ce); end
        checks++; if (bif.bus_inv_ready !== 1'b0) begin failures++; $display("FAIL reset_inv_ready: got %b want 0", bif.bus_inv_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss_hit;
        logic [31:0] rd; int n; bit got; int r0, c0;
        r0 = bus_reads;
        do_req(1'b0, 32'h1004, '0, '0, rd, n, got);
        checks++; if (!got) begin failures++; $display("FAIL miss_resp: no resp_valid within bound"); end
        checks++; if (rd !== 32'hBBBB_BBBB) begin failures++; $display("FAIL miss_data: got %h want bbbbbbbb", rd); end
        checks++; if (n != 4) begin failures++; $display("FAIL miss_latency: got %0d want 4", n); end
        checks++; if (bus_reads != r0 + 1) begin failures++; $display("FAIL miss_bus_reads: got %0d want %0d", bus_reads, r0 + 1); end
        checks++; if (last_rd_addr !== 32'h1000) begin failures++; $display("FAIL miss_bus_addr: got %h want 00001000", last_rd_addr); end
        c0 = bus_cycles;
        do_req(1'b0, 32'h1004, '0, '0, rd, n, got);
        checks++; if (rd !== 32'hBBBB_BBBB) begin failures++; $display("FAIL hit_data: got %h want bbbbbbbb", rd); end
        checks++; if (n != 1) begin failures++; $display("FAIL hit_latency: got %0d want 1", n); end
        checks++; if (bus_cycles != c0) begin failures++; $display("FAIL hit_no_bus: got %0d bus cycles want 0", bus_cycles - c0); end
        do_req(1'b0, 32'h100C, '0, '0, rd, n, got);
        checks++; if (rd !== 32'hDDDD_DDDD || n != 1) begin failures++; $display("FAIL hit_word3: got %h lat %0d want dddddddd lat 1", rd, n); end
    endtask

    task automatic test_write;
        logic [31:0] rd; int n; bit got; int w0, r0;
        w0 = bus_writes;
        do_req(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'hF, rd, n, got);
        checks++; if (!got || rd !== 32'h0) begin failures++; $display("FAIL wr_resp: got valid %b data %h want 1 0", got, rd); end
        checks++; if (n != 4) begin failures++; $display("FAIL wr_latency: got %0d want 4", n); end
        checks++; if (bus_writes != w0 + 1) begin failures++; $display("FAIL wr_count: got %0d want %0d", bus_writes, w0 + 1); end
        checks++; if (last_w_mask !== 16'h0F00) begin failures++; $display("FAIL wr_mask: got %h want 0f00", last_w_mask); end
        checks++; if (last_w_ce !== 1'b1) begin failures++; $display("FAIL wr_ce: got %b want 1", last_w_ce); end
        checks++; if (last_w_data !== {4{32'hDEAD_BEEF}}) begin failures++; $display("FAIL wr_data: got %h want 4x deadbeef", last_w_data); end
        checks++; if (last_w_addr !== 32'h1000) begin failures++; $display("FAIL wr_addr: got %h want 00001000", last_w_addr); end
        r0 = bus_reads;
        do_req(1'b0, 32'h1008, '0, '0, rd, n, got);
        checks++; if (n != 4 || bus_reads != r0 + 1) begin failures++; $display("FAIL wr_then_miss: got lat %0d reads %0d want 4 %0d", n, bus_reads, r0 + 1); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_refetch_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_invalidate;
        logic [31:0] rd; int n; bit got; logic rs;
        do_req(1'b0, 32'h2000, '0, '0, rd, n, got);
        checks++; if (rd !== 32'hC0DE_2000 || n != 4) begin failures++; $display("FAIL inv_fill: got %h lat %0d want c0de2000 lat 4", rd, n); end
        inv_pulse(32'h6000, rs);
        checks++; if (rs !== 1'b1) begin failures++; $display("FAIL inv_ready_other: got %b want 1", rs); end
        do_req(1'b0, 32'h2000, '0, '0, rd, n, got);
        checks++; if (n != 1) begin failures++; $display("FAIL inv_other_tag_kept: got lat %0d want 1", n); end
        inv_pulse(32'h2000, rs);
        checks++; if (rs !== 1'b1) begin failures++; $display("FAIL inv_ready_match: got %b want 1", rs); end
        do_req(1'b0, 32'h2000, '0, '0, rd, n, got);
        checks++; if (n != 4) begin failures++; $display("FAIL inv_match_miss: got lat %0d want 4", n); end
    endtask

    task automatic test_poison;
        logic [31:0] rd; int n; bit got; logic rs; int r0;
        r0 = bus_reads;
        lat_cfg = 5;
        bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_addr = 32'h3000;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        n = 0;
        while (!bif.bus_rw_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (bif.bus_rw_valid !== 1'b1) begin failures++; $display("FAIL poison_bus_req: got %b want 1", bif.bus_rw_valid); end
        inv_pulse(32'h3000, rs);
        n = 0;
        while (!bif.resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (bif.resp_valid !== 1'b1 || bif.resp_rdata !== 32'hC0DE_3000) begin failures++; $display("FAIL poison_data: got %b %h want 1 c0de3000", bif.resp_valid, bif.resp_rdata); end
        @(posedge clk); #1;
        lat_cfg = 2;
        do_req(1'b0, 32'h3000, '0, '0, rd, n, got);
        checks++; if (n != 4 || bus_reads != r0 + 2) begin failures++; $display("FAIL poison_not_installed: got lat %0d reads %0d want 4 %0d", n, bus_reads, r0 + 2); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; int n; bit got; bit seen;
        do_req(1'b0, 32'h1000, '0, '0, rd, n, got);
        hold_bus = 1'b1;
        bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_addr = 32'h1400;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        n = 0;
        while (!bif.bus_rw_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (bif.bus_rw_valid !== 1'b1) begin failures++; $display("FAIL rstmid_in_rd_bus: got %b want 1", bif.bus_rw_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bif.bus_rw_valid !== 1'b0) begin failures++; $display("FAIL rstmid_bus_drop: got %b want 0", bif.bus_rw_valid); end
        checks++; if (bif.req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_req_ready: got %b want 1", bif.req_ready); end
        rst = 1'b0;
        hold_bus = 1'b0;
        seen = bif.resp_valid;
        repeat (5) begin @(posedge clk); #1; if (bif.resp_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp: got resp_valid %b want 0", seen); end
        do_req(1'b0, 32'h1000, '0, '0, rd, n, got);
        checks++; if (n != 4) begin failures++; $display("FAIL rstmid_lines_invalid: got lat %0d want 4", n); end
    endtask

    task automatic test_conflict;
        logic [31:0] rd; int n; bit got;
        do_req(1'b0, 32'h1000, '0, '0, rd, n, got);
        checks++; if (n != 1 || rd !== 32'hAAAA_AAAA) begin failures++; $display("FAIL conf_hit: got %h lat %0d want aaaaaaaa lat 1", rd, n); end
        do_req(1'b0, 32'h1400, '0, '0, rd, n, got);
        checks++; if (n != 4 || rd !== 32'hC0DE_1400) begin failures++; $display("FAIL conf_fill: got %h lat %0d want c0de1400 lat 4", rd, n); end
        do_req(1'b0, 32'h1000, '0, '0, rd, n, got);
        checks++; if (n != 4 || rd !== 32'hAAAA_AAAA) begin failures++; $display("FAIL conf_evicted: got %h lat %0d want aaaaaaaa lat 4", rd, n); end
        do_req(1'b0, 32'h1000, '0, '0, rd, n, got);
        checks++; if (n != 1) begin failures++; $display("FAIL conf_refill_hit: got lat %0d want 1", n); end
    endtask

    initial begin
        bif.req_valid     = 1'b0;
        bif.req_we        = 1'b0;
        bif.req_addr      = '0;
        bif.req_wdata     = '0;
        bif.req_wmask     = '0;
        bif.bus_inv_valid = 1'b0;
        bif.bus_inv_addr  = '0;
        test_reset;
        test_read_miss_hit;
        test_write;
        test_invalidate;
        test_poison;
        test_reset_mid;
        test_conflict;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
